// File: rtl/clk_div_ctrl.sv
// Sequencing front-end for clock_divider: accepts range-checked divisor changes,
// restarts the divider through div_rst and reports lock after enough clk_out toggles.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_HOLD    | div_rst held high while hold_cnt counts down
// S_WAIT    | divider running, counting clk_out toggles toward LOCK_EDGES
// S_IDLE    | locked; accepting divisor-change requests
module clk_div_ctrl #(
  parameter logic [31:0] DEFAULT_DIV = 32'd50,
  parameter logic [31:0] MIN_DIV     = 32'd1,
  parameter logic [31:0] MAX_DIV     = 32'hFFFF_FFFF,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned LOCK_EDGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_divisor,
  output logic        req_ready,
  input  logic        div_clk_out,
  output logic [31:0] divisor,
  output logic        div_rst,
  output logic        locked,
  output logic        err
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int EW = $clog2(LOCK_EDGES) + 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(LOCK_EDGES);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_WAIT = 2'd1,
    S_IDLE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic          clk_q, clk_d;
  logic [31:0]   divisor_q, divisor_d;
  logic          div_rst_q, div_rst_d;
  logic          locked_q, locked_d;
  logic          req_ready_q, req_ready_d;
  logic          err_q, err_d;
  logic          toggle;
  logic          in_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_HOLD;
      hold_cnt_q  <= HOLD_INIT;
      edge_cnt_q  <= '0;
      clk_q       <= 1'b0;
      divisor_q   <= DEFAULT_DIV;
      div_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
      req_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      clk_q       <= clk_d;
      divisor_q   <= divisor_d;
      div_rst_q   <= div_rst_d;
      locked_q    <= locked_d;
      req_ready_q <= req_ready_d;
      err_q       <= err_d;
    end
  end

  // Compared in 33 bits so full-range bounds stay ordinary compares.
  assign in_range = ({1'b0, req_divisor} >= {1'b0, MIN_DIV}) &&
                    ({1'b0, req_divisor} <= {1'b0, MAX_DIV});
  assign toggle   = div_clk_out ^ clk_q;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    clk_d       = div_clk_out;
    divisor_d   = divisor_q;
    div_rst_d   = div_rst_q;
    locked_d    = locked_q;
    req_ready_d = req_ready_q;
    err_d       = 1'b0;

    unique case (state_q)
      S_HOLD: begin
        div_rst_d   = 1'b1;
        locked_d    = 1'b0;
        req_ready_d = 1'b0;
        if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end else begin
          state_d    = S_WAIT;
          div_rst_d  = 1'b0;
          edge_cnt_d = '0;
        end
      end

      S_WAIT: begin
        if (toggle) begin
          edge_cnt_d = edge_cnt_q + 1'b1;
          if (edge_cnt_d == EDGE_LAST) begin
            state_d     = S_IDLE;
            locked_d    = 1'b1;
            req_ready_d = 1'b1;
          end
        end
      end

      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (in_range) begin
            divisor_d   = req_divisor;
            locked_d    = 1'b0;
            req_ready_d = 1'b0;
            div_rst_d   = 1'b1;
            hold_cnt_d  = HOLD_INIT;
            state_d     = S_HOLD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: state_d = S_HOLD;
    endcase
  end

  assign req_ready = req_ready_q;
  assign divisor   = divisor_q;
  assign div_rst   = div_rst_q;
  assign locked    = locked_q;
  assign err       = err_q;

endmodule
